pe_inner_fsm: RTL

//   Next-generation inner-product PE for the unary-temporal systolic array. Multiplies a temporal
//   (thermometer) input bitstream by a rate-coded weight over a programmable window of cycles, with
//   no external mac_done. Accumulates signed +/-1 products locally and adds them once to the

---
 rtl/pe_inner_fsm_if.sv | 29 ++
 rtl/pe_inner_fsm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pe_inner_fsm_if.sv
`default_nettype none
// ============================================================================
// pe_inner_fsm_if : systolic link between neighbouring inner-product PEs
// Rev 1.0
// ============================================================================
interface pe_inner_fsm_if #(
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 16
);
    logic              start;
    logic              ifm_bit;
    logic              ifm_sign;
    logic [IWIDTH-2:0] randW;
    logic              w_load;
    logic              w_sign;
    logic [IWIDTH-2:0] w_abs;
    logic              psum_valid;
    logic [OWIDTH-1:0] psum;

    modport master (
        output start, ifm_bit, ifm_sign, randW, w_load, w_sign, w_abs,
        output psum_valid, psum
    );
    modport slave (
        input  start, ifm_bit, ifm_sign, randW, w_load, w_sign, w_abs,
        input  psum_valid, psum
    );
endinterface
`default_nettype wire

// File: rtl/pe_inner_fsm.sv
`default_nettype none
// ============================================================================
// pe_inner_fsm : unary-temporal inner-product PE with self-timed MAC window
// Rev 1.0
// ============================================================================
module pe_inner_fsm #(
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 16,
    parameter int SAT    = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [IWIDTH-2:0] cfg_len,
    pe_inner_fsm_if.slave          up,
    pe_inner_fsm_if.master         dn,
    output logic                   busy,
    output logic                   sat_flag,
    output logic                   err
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_WAIT = 2'd2} state_t;

    localparam logic [IWIDTH-1:0] C_ONE   = {{(IWIDTH-1){1'b0}}, 1'b1};
    localparam logic [IWIDTH-1:0] C_MAXW  = {1'b1, {(IWIDTH-1){1'b0}}};
    localparam logic [OWIDTH-1:0] C_SMAX  = {1'b0, {(OWIDTH-1){1'b1}}};
    localparam logic [OWIDTH-1:0] C_SMIN  = {1'b1, {(OWIDTH-1){1'b0}}};

    state_t            state_q, state_d;
    logic [IWIDTH-1:0] cnt_q, cnt_d, len_q, len_d, acc_q, acc_d;
    logic              sh_sign_q, sh_sign_d, act_sign_q, act_sign_d, isign_q, isign_d;
    logic [IWIDTH-2:0] sh_abs_q, sh_abs_d, act_abs_q, act_abs_d;
    logic              buf_full_q, buf_full_d;
    logic [OWIDTH-1:0] buf_q, buf_d, psum_o_q, psum_o_d;
    logic              psum_valid_o_q, psum_valid_o_d, sat_q, sat_d, err_q, err_d;
    logic              fwd_start_q, fwd_bit_q, fwd_isign_q, fwd_wload_q, fwd_wsign_q;
    logic [IWIDTH-2:0] fwd_randw_q, fwd_wabs_q;

    logic              w_exit, w_accept, w_sel_sign, w_sel_isign, w_prod;
    logic [IWIDTH-2:0] w_sel_abs;
    logic [IWIDTH-1:0] w_len_eff, w_delta;
    logic [OWIDTH-1:0] w_operand, w_result;
    logic [OWIDTH:0]   w_sum;
    logic              w_ovf;

    always_comb begin
        w_len_eff   = (cfg_len == '0) ? C_MAXW : {1'b0, cfg_len};
        w_exit      = (state_q == S_WAIT) && (buf_full_q || up.psum_valid);
        w_accept    = up.start && ((state_q == S_IDLE) || w_exit);
        // The accept cycle already carries bit 0, so it uses the incoming weight/sign.
        w_sel_sign  = w_accept ? (up.w_load ? up.w_sign : sh_sign_q) : act_sign_q;
        w_sel_abs   = w_accept ? (up.w_load ? up.w_abs  : sh_abs_q)  : act_abs_q;
        w_sel_isign = w_accept ? up.ifm_sign : isign_q;
        w_prod      = up.ifm_bit && (up.randW < w_sel_abs);
        w_delta     = !w_prod ? '0 : ((w_sel_isign ^ w_sel_sign) ? '1 : C_ONE);

        w_operand   = buf_full_q ? buf_q : up.psum;
        w_sum       = {{(OWIDTH+1-IWIDTH){acc_q[IWIDTH-1]}}, acc_q}
                    + {w_operand[OWIDTH-1], w_operand};
        w_ovf       = w_sum[OWIDTH] ^ w_sum[OWIDTH-1];
        if (SAT != 0 && w_ovf) w_result = w_sum[OWIDTH] ? C_SMIN : C_SMAX;
        else                   w_result = w_sum[OWIDTH-1:0];
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        len_d          = len_q;
        acc_d          = acc_q;
        sh_sign_d      = up.w_load ? up.w_sign : sh_sign_q;
        sh_abs_d       = up.w_load ? up.w_abs  : sh_abs_q;
        act_sign_d     = act_sign_q;
        act_abs_d      = act_abs_q;
        isign_d        = isign_q;
        buf_full_d     = buf_full_q;
        buf_d          = buf_q;
        psum_o_d       = psum_o_q;
        psum_valid_o_d = 1'b0;
        sat_d          = sat_q;
        err_d          = err_q;

        if (state_q != S_WAIT && up.psum_valid) begin
            if (buf_full_q) err_d = 1'b1;
            else begin
                buf_d      = up.psum;
                buf_full_d = 1'b1;
            end
        end

        case (state_q)
            S_RUN: begin
                acc_d = acc_q + w_delta;
                cnt_d = cnt_q + C_ONE;
                if (cnt_q == len_q - C_ONE) state_d = S_WAIT;
                if (up.start) err_d = 1'b1;
            end
            S_WAIT: begin
                if (buf_full_q && up.psum_valid) err_d = 1'b1;
                if (w_exit) begin
                    psum_o_d       = w_result;
                    psum_valid_o_d = 1'b1;
                    buf_full_d     = 1'b0;
                    state_d        = S_IDLE;
                    if (w_ovf) sat_d = 1'b1;
                end else if (up.start) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (w_accept) begin
            len_d      = w_len_eff;
            isign_d    = up.ifm_sign;
            act_sign_d = w_sel_sign;
            act_abs_d  = w_sel_abs;
            acc_d      = w_delta;
            cnt_d      = C_ONE;
            state_d    = (w_len_eff == C_ONE) ? S_WAIT : S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            len_q          <= '0;
            acc_q          <= '0;
            sh_sign_q      <= 1'b0;
            sh_abs_q       <= '0;
            act_sign_q     <= 1'b0;
            act_abs_q      <= '0;
            isign_q        <= 1'b0;
            buf_full_q     <= 1'b0;
            buf_q          <= '0;
            psum_o_q       <= '0;
            psum_valid_o_q <= 1'b0;
            sat_q          <= 1'b0;
            err_q          <= 1'b0;
            fwd_start_q    <= 1'b0;
            fwd_bit_q      <= 1'b0;
            fwd_isign_q    <= 1'b0;
            fwd_randw_q    <= '0;
            fwd_wload_q    <= 1'b0;
            fwd_wsign_q    <= 1'b0;
            fwd_wabs_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            len_q          <= len_d;
            acc_q          <= acc_d;
            sh_sign_q      <= sh_sign_d;
            sh_abs_q       <= sh_abs_d;
            act_sign_q     <= act_sign_d;
            act_abs_q      <= act_abs_d;
            isign_q        <= isign_d;
            buf_full_q     <= buf_full_d;
            buf_q          <= buf_d;
            psum_o_q       <= psum_o_d;
            psum_valid_o_q <= psum_valid_o_d;
            sat_q          <= sat_d;
            err_q          <= err_d;
            fwd_start_q    <= up.start;
            fwd_bit_q      <= up.ifm_bit;
            fwd_isign_q    <= up.ifm_sign;
            fwd_randw_q    <= up.randW;
            fwd_wload_q    <= up.w_load;
            fwd_wsign_q    <= up.w_sign;
            fwd_wabs_q     <= up.w_abs;
        end
    end

    assign dn.start      = fwd_start_q;
    assign dn.ifm_bit    = fwd_bit_q;
    assign dn.ifm_sign   = fwd_isign_q;
    assign dn.randW      = fwd_randw_q;
    assign dn.w_load     = fwd_wload_q;
    assign dn.w_sign     = fwd_wsign_q;
    assign dn.w_abs      = fwd_wabs_q;
    assign dn.psum_valid = psum_valid_o_q;
    assign dn.psum       = psum_o_q;
    assign busy          = (state_q != S_IDLE);
    assign sat_flag      = sat_q;
    assign err           = err_q;
endmodule
`default_nettype wire
